// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (lw/sw/R-type/beq/addi/j) with a memory wait timeout.
// Outputs are decoded from the state and, in FETCH/DECODE, from mem_ready/opcode. A stalled memory is held off by waiting in place.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_ERROR  = 4'd12
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait_cnt;
    logic          r_is_sw;
    logic          r_mem_err;
    logic          w_wait;
    logic          w_timeout;
    logic          w_legal;

    assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                       && !mem_ready;
    // This is the TIMEOUT_CYCLES-th consecutive stalled cycle: give up at its end.
    assign w_timeout = w_wait && (r_wait_cnt >= CW'(TIMEOUT_CYCLES - 1));
    assign w_legal   = (opcode == OP_RTYPE) || (opcode == OP_J) || (opcode == OP_BEQ) ||
                       (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_is_sw    <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_wait && (r_wait_cnt != CW'(TIMEOUT_CYCLES))) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
            if (w_next == S_ERROR) begin
                r_mem_err <= 1'b1;
            end
            // The IR may change after DECODE, so remember lw vs sw for MEMADR.
            if (r_state == S_DECODE) begin
                r_is_sw <= (opcode == OP_SW);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = r_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        illegal_op    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'd3;
                illegal_op = !w_legal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign state   = r_state;
    assign mem_err = r_mem_err;

endmodule
